sin_lut_arbiter: RTL and testbench
==================================

// Module: sin_lut_arbiter
// PURPOSE
//  Shares one sin_lut instance between N phase requesters (tremolo LFO, vibrato LFO, chorus, ...).
//  Round-robin arbitrates one lookup per cycle and drives the LUT phase.
//  Tracks in-flight lookups through the LUT pipeline and returns each sample to its requester.
//  Sits between the per-effect phase accumulators and a single sin_lut, replacing per-effect LUT copies.
// PARAMETERS
//  N          4   number of requesters (>=2)
//  PHI_WIDTH  8   phase width = $clog2(LUT DEPTH)
//  WIDTH      24  LUT sample width
//  LUT_LAT    1   sin_lut read latency, phi-in to wav-out (>=1)
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous active-high reset
//  req        in   N            per-requester lookup request; level, held until gnt
//  phi        in   N*PHI_WIDTH  per-requester phase; slice i = phi[i*PHI_WIDTH +: PHI_WIDTH]
//  gnt        out  N            one-hot/zero grant, combinational from req and RR pointer
//  lut_phi    out  PHI_WIDTH    registered phase to sin_lut.phi
//  lut_wav    in   WIDTH        sin_lut.wav
//  rsp_valid  out  N            one-hot/zero; marks the requester that owns rsp_wav this cycle
//  rsp_wav    out  WIDTH        sample = lut_wav, passed through unregistered
// BEHAVIOUR
//  - Handshake: transfer in cycle t when req[i] & gnt[i]; phi slice i is sampled at the end of t.
//  - req may drop without a grant; no lookup results. gnt never asserts for a requester with req=0.
//  - Arbitration: RR pointer ptr holds the last granted index.
//    - Search order is ptr+1, ptr+2, ... mod N; the first set req wins.
//    - ptr <= winner only on a grant; with no req, ptr and lut_phi hold.
//  - lut_phi <= phi[winner] at the end of t; reset value 0.
//  - Tag pipeline: LUT_LAT+1 stages of {valid, idx}, advancing every cycle (no stall).
//  - Response: rsp_valid[i]=1 in cycle t+1+LUT_LAT, with rsp_wav = lut_wav.
//    - Total latency from handshake to response: LUT_LAT+1 cycles.
//    - Responses return in grant order; throughput is 1 lookup/cycle.
//  - Single persistent requester: granted every cycle, with back-to-back responses.
//  - N not a power of 2: pointer wraps from N-1 to 0 explicitly.
//  - Reset values: ptr=N-1 (requester 0 wins first), lut_phi=0, all tag valids=0, rsp_valid=0.
//  - gnt=0 while rst is high.
//  - Reset mid-operation: in-flight lookups are dropped, with no rsp_valid for them.
//    - The arbiter restarts from ptr=N-1 on the first cycle after rst deasserts.
// CONFIGURATION
//  SIN_ARB_PRIO0_EN defined:
//    - Requester 0 (audio-rate path) is fixed highest priority; req[0]=1 always wins.
//    - ptr is unchanged when 0 wins.
//    - Requesters 1..N-1 round-robin among themselves when req[0]=0.
//  SIN_ARB_PRIO0_EN undefined: pure round-robin over all N, as above.
// TESTING  (N=4, PHI_WIDTH=8, LUT_LAT=1, model sin_lut with lut_wav = phase*3, 1-cycle registered)
//  1. Reset then req=4'b0000 for 10 cycles -> gnt=0, rsp_valid=0, lut_phi stays 0.
//  2. req=4'b1111 held, phi={8'h40,8'h30,8'h20,8'h10} -> gnt order 0,1,2,3,0 per cycle.
//     - rsp_valid order 0,1,2,3 starting 2 cycles after the first grant; rsp_wav = 0x30,0x60,0x90,0xC0.
//  3. Only req[2]=1, phi slice 2 = 8'hFF held 5 cycles -> gnt[2] every cycle.
//     - 5 consecutive rsp_valid[2] pulses, rsp_wav=0x2FD each.
//  4. Single cycle with req=4'b0101, ptr=0 -> gnt=4'b0100; next cycle req=4'b0001 -> gnt=4'b0001.
//  5. Grant to requester 1, then rst pulsed 1 cycle before its response -> no rsp_valid.
//     - First grant after reset goes to the lowest-index requester per RR from ptr=N-1.
//  6. SIN_ARB_PRIO0_EN defined, req=4'b1111 held -> gnt=4'b0001 every cycle.
//     - Drop req[0] -> grants rotate 1,2,3,1.

Source files
------------

// File: rtl/sin_lut_arbiter.sv
// Shares one sin_lut between N phase requesters: round-robin grant, registered LUT phase,
// tag pipeline that routes each LUT sample back to its requester. Option: SIN_ARB_PRIO0_EN.
module sin_lut_arbiter #(
  parameter int N         = 4,
  parameter int PHI_WIDTH = 8,
  parameter int WIDTH     = 24,
  parameter int LUT_LAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N*PHI_WIDTH-1:0] phi,
  output logic [N-1:0]           gnt,
  output logic [PHI_WIDTH-1:0]   lut_phi,
  input  logic [WIDTH-1:0]       lut_wav,
  output logic [N-1:0]           rsp_valid,
  output logic [WIDTH-1:0]       rsp_wav
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;

  logic             vld_p [0:LUT_LAT];
  logic [IDX_W-1:0] idx_p [0:LUT_LAT];

  // Winner search starts one past the last granted index and wraps N-1 -> 0.
  always_comb begin
    int c;
    win_vld = 1'b0;
    win_idx = ptr;
    gnt     = '0;
    c       = 0;
`ifdef SIN_ARB_PRIO0_EN
    if (req[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end
`endif
    for (int k = 1; k <= N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
`ifdef SIN_ARB_PRIO0_EN
      if (!win_vld && (c != 0) && req[c]) begin
`else
      if (!win_vld && req[c]) begin
`endif
        win_vld = 1'b1;
        win_idx = IDX_W'(c);
      end
    end
    if (rst) win_vld = 1'b0;
    if (win_vld) gnt[win_idx] = 1'b1;
  end

  // Stage p0: grant accepted, phase registered toward the LUT
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= IDX_W'(N - 1);
      lut_phi <= '0;
    end else if (win_vld) begin
      lut_phi <= phi[win_idx*PHI_WIDTH +: PHI_WIDTH];
`ifdef SIN_ARB_PRIO0_EN
      if (win_idx != '0) ptr <= win_idx;
`else
      ptr <= win_idx;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LUT_LAT; k++) vld_p[k] <= 1'b0;
    end else begin
      vld_p[0] <= win_vld;
      for (int k = 1; k <= LUT_LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    idx_p[0] <= win_idx;
    for (int k = 1; k <= LUT_LAT; k++) idx_p[k] <= idx_p[k-1];
  end

  // Stage p(LUT_LAT): tag lines up with the LUT output
  always_comb begin
    rsp_valid = '0;
    if (vld_p[LUT_LAT] && !rst) rsp_valid[idx_p[LUT_LAT]] = 1'b1;
  end

  assign rsp_wav = lut_wav;

endmodule

// File: tb/tb_sin_lut_arbiter.sv
// Directed bench for sin_lut_arbiter with a 1-cycle sin_lut model (wav = phase*3).
// Default build checks round-robin; SIN_ARB_PRIO0_EN selects the fixed-priority checks.
module tb_sin_lut_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] phi;
  logic [3:0]  gnt;
  logic [7:0]  lut_phi;
  logic [23:0] lut_wav;
  logic [3:0]  rsp_valid;
  logic [23:0] rsp_wav;
  int checks = 0;
  int errors = 0;

  sin_lut_arbiter #(.N(4), .PHI_WIDTH(8), .WIDTH(24), .LUT_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req), .phi(phi), .gnt(gnt), .lut_phi(lut_phi),
    .lut_wav(lut_wav), .rsp_valid(rsp_valid), .rsp_wav(rsp_wav)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) lut_wav <= {16'd0, lut_phi} * 24'd3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    phi = {8'h40, 8'h30, 8'h20, 8'h10};
    next_cycle();
    next_cycle();
    at_neg();
    chk("gnt_in_reset", 32'(gnt), 32'h0);
    chk("rsp_in_reset", 32'(rsp_valid), 32'h0);
    chk("lut_phi_reset", 32'(lut_phi), 32'h0);

    // Test 1: idle
    rst = 1'b0;
    req = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      at_neg();
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_rsp", 32'(rsp_valid), 32'h0);
      chk("idle_phi", 32'(lut_phi), 32'h0);
    end

`ifndef SIN_ARB_PRIO0_EN
    // Test 2: all four requesting
    next_cycle(); req = 4'b1111; at_neg();
    chk("rr_gnt0", 32'(gnt), 32'h1);
    chk("rr_rsp_t0", 32'(rsp_valid), 32'h0);
    next_cycle(); at_neg();
    chk("rr_gnt1", 32'(gnt), 32'h2);
    chk("rr_lut_phi", 32'(lut_phi), 32'h10);
    chk("rr_rsp_t1", 32'(rsp_valid), 32'h0);
    next_cycle(); at_neg();
    chk("rr_gnt2", 32'(gnt), 32'h4);
    chk("rr_rsp0", 32'(rsp_valid), 32'h1);
    chk("rr_wav0", 32'(rsp_wav), 32'h30);
    next_cycle(); at_neg();
    chk("rr_gnt3", 32'(gnt), 32'h8);
    chk("rr_rsp1", 32'(rsp_valid), 32'h2);
    chk("rr_wav1", 32'(rsp_wav), 32'h60);
    next_cycle(); at_neg();
    chk("rr_gnt4", 32'(gnt), 32'h1);
    chk("rr_rsp2", 32'(rsp_valid), 32'h4);
    chk("rr_wav2", 32'(rsp_wav), 32'h90);
    next_cycle(); req = 4'b0000; at_neg();
    chk("rr_gnt_off", 32'(gnt), 32'h0);
    chk("rr_rsp3", 32'(rsp_valid), 32'h8);
    chk("rr_wav3", 32'(rsp_wav), 32'hC0);
    next_cycle(); at_neg();
    chk("rr_rsp4", 32'(rsp_valid), 32'h1);
    chk("rr_wav4", 32'(rsp_wav), 32'h30);
    next_cycle(); at_neg();
    chk("rr_drained", 32'(rsp_valid), 32'h0);
    chk("rr_phi_hold", 32'(lut_phi), 32'h10);
`endif

    // Test 3: single persistent requester
    phi[23:16] = 8'hFF;
    next_cycle(); req = 4'b0100;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) req = 4'b0000;
      at_neg();
      chk("solo_gnt", 32'(gnt), (i < 5) ? 32'h4 : 32'h0);
      chk("solo_rsp", 32'(rsp_valid), (i >= 2) ? 32'h4 : 32'h0);
      if (i >= 2) chk("solo_wav", 32'(rsp_wav), 32'h2FD);
      next_cycle();
    end
    at_neg();
    chk("solo_drained", 32'(rsp_valid), 32'h0);

`ifndef SIN_ARB_PRIO0_EN
    // Test 4: pointer sets search order
    next_cycle(); req = 4'b0001; at_neg();
    chk("ptr_set_gnt", 32'(gnt), 32'h1);
    next_cycle(); req = 4'b0101; at_neg();
    chk("ptr0_gnt", 32'(gnt), 32'h4);
    next_cycle(); req = 4'b0001; at_neg();
    chk("ptr2_gnt", 32'(gnt), 32'h1);
    next_cycle(); req = 4'b0000;
    next_cycle(); next_cycle();
`endif

    // Test 5: reset drops an in-flight lookup
    next_cycle(); req = 4'b0010; at_neg();
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    next_cycle(); req = 4'b0000; rst = 1'b1; at_neg();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rsp", 32'(rsp_valid), 32'h0);
    next_cycle(); rst = 1'b0; req = 4'b1111; at_neg();
    chk("dropped_rsp", 32'(rsp_valid), 32'h0);
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    chk("post_rst_phi", 32'(lut_phi), 32'h0);
    next_cycle(); req = 4'b0000; at_neg();
    chk("post_rst_rsp_t1", 32'(rsp_valid), 32'h0);
    next_cycle(); at_neg();
    chk("post_rst_rsp", 32'(rsp_valid), 32'h1);
    chk("post_rst_wav", 32'(rsp_wav), 32'h30);

`ifdef SIN_ARB_PRIO0_EN
    // Test 6: requester 0 fixed priority
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0; req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("prio_gnt0", 32'(gnt), 32'h1);
      next_cycle();
    end
    req = 4'b1110; at_neg();
    chk("prio_rr1", 32'(gnt), 32'h2);
    next_cycle(); at_neg();
    chk("prio_rr2", 32'(gnt), 32'h4);
    next_cycle(); at_neg();
    chk("prio_rr3", 32'(gnt), 32'h8);
    next_cycle(); at_neg();
    chk("prio_rr1b", 32'(gnt), 32'h2);
    next_cycle(); req = 4'b0000;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
